// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared types and helpers for the down_timer slice
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Prescaler counter width; a single-cycle prescaler still gets one bit
  function automatic int presc_width(input int prescale);
    if (prescale <= 2) return 1;
    return $clog2(prescale);
  endfunction

endpackage

// File: rtl/down_timer_if.sv
// rtl/down_timer_if.sv - control/status bundle between a controller and down_timer
interface down_timer_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load, load_val, en, auto_reload,
    input  out, busy, done, tc
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output out, busy, done, tc
  );

endinterface

// File: rtl/down_timer_tick_prescaler.sv
// rtl/down_timer_tick_prescaler.sv - divides enabled cycles into count ticks
module tick_prescaler
  import down_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Count enabled cycles 0..PRESCALE-1; with PRESCALE=1 cnt stays 0 and tick follows en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counting timer with terminal count and auto-reload
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic        clk,
  input logic        rst,
  down_timer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic             tick;

  // Prescaler only advances while running; a load restarts the phase
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.load),
    .en    (bus.en && (state_q == S_RUN)),
    .tick  (tick)
  );

  // Next state, next count and terminal-count pulse; load overrides everything
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      out_d   = bus.load_val;
      state_d = (bus.load_val != '0) ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (tick) begin
            if (out_q > WIDTH'(1)) begin
              out_d = out_q - 1'b1;
            end else begin
              tc_d = 1'b1;
              if (bus.auto_reload) begin
                out_d = reload_q;
              end else begin
                out_d   = '0;
                state_d = S_DONE;
              end
            end
          end
        end
        S_DONE:  out_d = '0;
        default: ;
      endcase
    end
  end

  // State, count, reload value and registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      if (bus.load) reload_q <= bus.load_val;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - scoreboard bench for down_timer at PRESCALE 1 and 4
module tb_down_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  down_timer_if #(.WIDTH(4)) b1 ();
  down_timer_if #(.WIDTH(4)) b4 ();

  down_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  down_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  logic       t_load [2];
  logic [3:0] t_val  [2];
  logic       t_en   [2];
  logic       t_ar   [2];

  assign b1.load = t_load[0];  assign b1.load_val = t_val[0];
  assign b1.en   = t_en[0];    assign b1.auto_reload = t_ar[0];
  assign b4.load = t_load[1];  assign b4.load_val = t_val[1];
  assign b4.en   = t_en[1];    assign b4.auto_reload = t_ar[1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: m_st 0=idle 1=run 2=done; m_ph counts enabled run cycles
  int pre [2] = '{1, 4};
  int m_out [2], m_rel [2], m_ph [2], m_st [2], m_tc [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 0; m_rel[d] = 0; m_ph[d] = 0; m_st[d] = 0; m_tc[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    m_tc[d] = 0;
    if (t_load[d]) begin
      m_out[d] = int'(t_val[d]);
      m_rel[d] = int'(t_val[d]);
      m_ph[d]  = 0;
      m_st[d]  = (t_val[d] != 0) ? 1 : 0;
    end else if (m_st[d] == 1 && t_en[d]) begin
      m_ph[d]++;
      if (m_ph[d] == pre[d]) begin
        m_ph[d] = 0;
        if (m_out[d] == 1) begin
          m_tc[d] = 1;
          if (t_ar[d]) m_out[d] = m_rel[d];
          else begin m_out[d] = 0; m_st[d] = 2; end
        end else begin
          m_out[d] = m_out[d] - 1;
        end
      end
    end
  endtask

  typedef struct {
    int d;
    int out;
    int busy;
    int done;
    int tc;
  } exp_t;

  exp_t sbq [$];

  // One clock: predict both timers, push, let the edge happen, pop and compare
  task automatic cycle();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      e.d = d; e.out = m_out[d]; e.busy = int'(m_st[d] == 1);
      e.done = int'(m_st[d] == 2); e.tc = m_tc[d];
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.d == 0) begin
        check("p1.out", int'(b1.out), e.out);   check("p1.busy", int'(b1.busy), e.busy);
        check("p1.done", int'(b1.done), e.done); check("p1.tc", int'(b1.tc), e.tc);
      end else begin
        check("p4.out", int'(b4.out), e.out);   check("p4.busy", int'(b4.busy), e.busy);
        check("p4.done", int'(b4.done), e.done); check("p4.tc", int'(b4.tc), e.tc);
      end
    end
  endtask

  task automatic drive(input int d, input logic ld, input int v, input logic en, input logic ar);
    t_load[d] = ld; t_val[d] = 4'(v); t_en[d] = en; t_ar[d] = ar;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int tcs;
    int n;
    bit seen;
    bit saw15;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    model_reset();
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst.out", int'(b1.out), 0);   check("rst.busy", int'(b1.busy), 0);
    check("rst.done", int'(b1.done), 0); check("rst.tc", int'(b1.tc), 0);
    check("rst.out4", int'(b4.out), 0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // One-shot expiry from 5 with single-cycle prescale
    drive(0, 1, 5, 1, 0); cycle();
    t_load[0] = 0;
    tcs = 0;
    for (int i = 0; i < 5; i++) begin cycle(); tcs += int'(b1.tc); end
    check("oneshot.tc_count", tcs, 1);
    check("oneshot.out", int'(b1.out), 0);
    check("oneshot.done", int'(b1.done), 1);
    for (int i = 0; i < 10; i++) cycle();
    check("oneshot.hold", int'(b1.out), 0);

    // Auto-reload from 3 for 12 cycles
    drive(0, 1, 3, 1, 1); cycle();
    t_load[0] = 0;
    tcs = 0;
    for (int i = 0; i < 12; i++) begin cycle(); tcs += int'(b1.tc); end
    check("reload.tc_count", tcs, 4);
    check("reload.out", int'(b1.out), 3);
    check("reload.done", int'(b1.done), 0);
    drive(0, 1, 0, 0, 0); cycle();
    t_load[0] = 0;

    // PRESCALE=4: steps every 4 enabled edges
    drive(1, 1, 2, 1, 0); cycle();
    t_load[1] = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("p4.edge4", int'(b4.out), 1);
    for (int i = 0; i < 4; i++) cycle();
    check("p4.edge8.out", int'(b4.out), 0);
    check("p4.edge8.tc", int'(b4.tc), 1);

    // Enable gap of 3 cycles delays expiry by 3
    drive(1, 1, 2, 1, 0); cycle();
    t_load[1] = 0;
    seen = 0; n = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      t_en[1] = !(i >= 3 && i <= 5);
      cycle();
      if (b4.tc) begin seen = 1; n = i; end
    end
    check("p4.gap_expiry", n, 11);
    drive(1, 0, 0, 0, 0);

    // Load coincident with terminal tick wins, then load 0 goes idle
    drive(0, 1, 4, 1, 0); cycle();
    t_load[0] = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("ld_tick.pre", int'(b1.out), 1);
    drive(0, 1, 9, 1, 0); cycle();
    check("ld_tick.out", int'(b1.out), 9);
    check("ld_tick.tc", int'(b1.tc), 0);
    check("ld_tick.busy", int'(b1.busy), 1);
    drive(0, 1, 0, 1, 0); cycle();
    check("ld_zero.out", int'(b1.out), 0);
    check("ld_zero.busy", int'(b1.busy), 0);
    t_load[0] = 0;
    cycle();

    // Asynchronous reset mid-count
    drive(0, 1, 15, 1, 0); cycle();
    t_load[0] = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("async.pre", int'(b1.out), 9);
    #2 rst = 1'b0;
    #3;
    check("async.out", int'(b1.out), 0);   check("async.busy", int'(b1.busy), 0);
    check("async.done", int'(b1.done), 0); check("async.tc", int'(b1.tc), 0);
    model_reset();
    #3 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) cycle();
    check("async.after", int'(b1.out), 0);

    // Max value runs down through 1 to 0 without wrapping
    drive(0, 1, 15, 1, 0); cycle();
    t_load[0] = 0;
    saw15 = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (b1.out == 4'd15) saw15 = 1;
    end
    check("max.no_wrap", int'(saw15), 0);
    check("max.done", int'(b1.done), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer, the counterpart to the team's 4-bit up counter. Software or a controller loads a start value; the block counts it down to zero on enabled prescaled ticks. At zero it flags a terminal count, then either stops or reloads automatically. It is used wherever the design needs a timeout, a delay or a periodic event instead of an elapsed-count tally.

## Interface
- `WIDTH`, 4: counter width in bits (≥2).
- `PRESCALE`, 1: enabled clock cycles per count step (≥1).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `load`  in  1  load `load_val` into the counter and the reload register.
- `load_val`  in  WIDTH  start/reload value.
- `en`  in  1  count enable; gates the prescaler and the counter.
- `auto_reload`  in  1  at terminal count, reload instead of stopping.
- `out`  out  WIDTH  current count.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (one-shot expiry), level.
- `tc`  out  1  terminal-count pulse, one cycle.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (`rst`=0, asynchronous): state=IDLE, `out`=0, reload_reg=0, prescaler=0, `busy`=`done`=`tc`=0.
- `load` has top priority in every state:
  - `out` and reload_reg take `load_val`, prescaler clears, `tc`=0.
  - If `load_val`≠0, next state is RUN. If `load_val`=0, next state is IDLE and `out`=0.
- IDLE: `out` holds; `en` and `auto_reload` are ignored.
- RUN:
  - Prescaler counts 0..PRESCALE-1 on cycles with `en`=1 and wraps to 0.
  - tick = `en` && prescaler==PRESCALE-1.
  - `en`=0 freezes both the prescaler and `out`.
  - On a tick with `out`>1: `out` decrements by 1.
  - On a tick with `out`=1: `tc`=1 for that cycle. `auto_reload` is sampled at this edge:
    - `auto_reload`=1: `out`=reload_reg, state stays RUN.
    - `auto_reload`=0: `out`=0, state goes to DONE.
- DONE: `out`=0, `done`=1. The block leaves DONE only on `load` or reset. `en` is ignored.
- Arithmetic: unsigned, modulo 2^WIDTH. `out` never decrements below 0 and never wraps to all-ones.
- `tc` is a registered pulse and is never high for two consecutive cycles unless reload_reg=1 with `auto_reload`, PRESCALE=1 and `en` held high.

## Timing
- Load at edge k: `out`=`load_val` and `busy`=1 are visible after edge k.
- First decrement: at the PRESCALE-th edge with `en`=1 after edge k.
- With `en` held high, expiry comes N·PRESCALE edges after the load, where N=`load_val`. `tc` and `done` assert together with `out`=0.
- `load` coincident with a tick or with terminal count: the load wins. No decrement, no `tc`.
- `rst` asserted mid-count: all outputs reach their reset values immediately, with no clock needed. Counting resumes only after `rst` deasserts and a new `load` arrives.

## Structure
- Package `down_timer_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - function for the prescaler counter width: $clog2(PRESCALE), minimum 1.
- Sub-module `tick_prescaler`:
  - Parameter PRESCALE.
  - Inputs: clk, rst, clear, en.
  - Output: tick.
  - When PRESCALE=1, tick=en combinationally.
- Top module holds the FSM, reload_reg, the `out` counter and the output registers.

## Test plan
- WIDTH=4, PRESCALE=1; load 5, `en`=1, `auto_reload`=0 → `out` goes 5,4,3,2,1,0 on consecutive edges; `tc` is a single pulse with `out`=0; `done`=1; `busy`=0; `out` holds 0 for 10 more cycles.
- Load 3, `auto_reload`=1, 12 cycles → `out` repeats 3,2,1 then back to 3; `tc` pulses every 3 cycles; `done` stays 0.
- PRESCALE=4; load 2, `en`=1 → `out`=1 at the 4th edge and `out`=0 with `tc` at the 8th edge; toggling `en` low for 3 cycles mid-run delays expiry by exactly 3 cycles.
- Load 4, run to `out`=1, then `load` with `load_val`=9 on the tick edge → `out`=9, no `tc`, state RUN; load 0 → `out`=0, IDLE, `busy`=0, no `tc`.
- Load 15, run 6 cycles (`out`=9), assert `rst` low between clock edges → `out`=0 and `busy`=`done`=`tc`=0 immediately; after release, `out` stays 0 until the next `load`.
- Load 15 (max value), run to expiry → `out` passes through 1 to 0 and never shows 15 again without a reload.
